fir_out_decimator: RTL and testbench
====================================

// Module: fir_out_decimator
// PURPOSE
//  Downstream stage of the FIR filter. Consumes the 16-bit FIR dataout stream
//  on a sample strobe and averages each block of 2^DECIM_LOG2 samples (boxcar
//  decimation). Results are buffered in a small FIFO with a valid/ready output
//  toward the sequence-decomposer arithmetic.
// PARAMETERS
//  DATA_W      16  width of FIR output sample and of averaged result
//  DECIM_LOG2  2   log2 of decimation ratio (samples averaged per output), >=1
//  DEPTH_LOG2  2   log2 of FIFO depth (default 4 entries)
// PORTS
//  clk       in   1       single clock, all logic on posedge
//  rst       in   1       synchronous reset, active-low (rst==0 resets on posedge clk)
//  in_valid  in   1       FIR sample strobe; in_data accepted every cycle it is 1
//  in_data   in   DATA_W  FIR output sample, unsigned
//  out_valid out  1       FIFO non-empty
//  out_ready in   1       consumer accepts head entry when out_valid&&out_ready
//  out_data  out  DATA_W  FIFO head entry; 0 when FIFO empty
//  fifo_full out  1       FIFO holds 2^DEPTH_LOG2 entries
//  overflow  out  1       sticky: a result was dropped because FIFO was full
//  ovf_clr   in   1       clears overflow (and drop_cnt when enabled)
// BEHAVIOUR
//  - Reset (rst==0): acc=0, sample cnt=0, rd/wr ptrs=0, count=0; out_valid=0,
//    out_data=0, fifo_full=0, overflow=0. Partial block and FIFO contents discarded.
//  - No input backpressure: in_valid always accepted.
//  - Accumulator width DATA_W+DECIM_LOG2; never wraps. Counter cnt 0..2^DECIM_LOG2-1.
//  - in_valid && cnt<max: acc<=acc+in_data, cnt<=cnt+1.
//  - in_valid && cnt==max: result=(acc+in_data)>>DECIM_LOG2 (truncate, floor);
//    push result; acc<=0, cnt<=0 on same edge.
//  - in_valid==0: acc, cnt hold (gaps between samples allowed).
//  - Latency: result written on the edge accepting the last sample; out_valid
//    and out_data visible the following cycle. No empty-FIFO bypass.
//  - Pop: out_valid&&out_ready -> rd_ptr advances; next head shown next cycle.
//  - Push accepted if !fifo_full OR pop in same cycle (simultaneous push+pop
//    when full: both succeed, count unchanged). Push+pop when non-full: count unchanged.
//  - Push when full and no pop: result dropped, FIFO unchanged, overflow<=1.
//  - ovf_clr clears overflow; if a drop occurs in the same cycle, set wins.
//  - Pointers wrap modulo 2^DEPTH_LOG2; full/empty from separate occupancy count
//    (DEPTH_LOG2+1 bits).
//  - out_ready while empty: no effect.
// CONFIGURATION
//  DROP_CNT_EN defined: adds output drop_cnt[7:0]; increments per dropped
//  result, saturates at 255, reset to 0, cleared by ovf_clr (drop in same
//  cycle -> drop_cnt<=1). Undefined: port and counter absent; overflow flag
//  behaviour identical either way.
// TESTING (DATA_W=16, DECIM_LOG2=2, DEPTH_LOG2=2, out_ready=1 unless stated)
//  1. Reset, in_valid on 4 cycles data 10,20,30,40 -> cycle after 4th:
//     out_valid=1, out_data=25; popped next edge, out_valid=0, out_data=0.
//  2. in_valid every other cycle, data 100,100,100,103 -> single result 100
//     (403>>2); no output before 4th sample.
//  3. Four samples 0xFFFF -> out_data=0xFFFF (no accumulator wrap).
//  4. out_ready=0, five 4-sample blocks (1s,2s,3s,4s,5s) -> fifo_full=1 after 4th,
//     5th dropped, overflow=1, drop_cnt=1 (DROP_CNT_EN); then out_ready=1 ->
//     reads 1,2,3,4 in order, out_valid=0 after; ovf_clr pulse -> overflow=0.
//  5. FIFO full, out_ready=1 on the edge the 4th sample of a block arrives ->
//     pop and push both succeed, fifo_full stays 1, overflow stays 0.
//  6. rst=0 for one cycle after 2 samples of 50 -> all outputs 0; then 4 samples
//     of 8 -> out_data=8 (no residue from aborted block).

Source files
------------

// File: rtl/fir_out_decimator.sv
// Boxcar decimator for the FIR output stream: averages blocks of 2^DECIM_LOG2
// samples into a small FIFO. Optional drop counter enabled by `define DROP_CNT_EN.
module fir_out_decimator #(
  parameter int DATA_W     = 16,
  parameter int DECIM_LOG2 = 2,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              fifo_full,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  // Handshake: an output entry transfers on a posedge where out_valid && out_ready;
  // out_valid never depends on out_ready, and the input side has no backpressure.

  logic [ACC_W-1:0]      r_acc;
  logic [DECIM_LOG2-1:0] r_cnt;
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_result;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_drop;

  assign w_sum     = r_acc + ACC_W'(in_data);
  assign w_result  = w_sum[ACC_W-1:DECIM_LOG2];
  assign w_push    = in_valid && (r_cnt == {DECIM_LOG2{1'b1}});
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL_CNT);
  assign w_pop     = !w_empty && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (in_valid) begin
      if (w_push) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + DECIM_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + (DEPTH_LOG2+1)'(1);
      else if (w_pop && !w_push_ok) r_count <= r_count - (DEPTH_LOG2+1)'(1);
    end
  end

  // Storage needs no reset: the occupancy count masks stale entries.
  always_ff @(posedge clk) begin
    if (rst && w_push_ok) r_mem[r_wr_ptr] <= w_result;
  end

  always_ff @(posedge clk) begin
    if (!rst)         r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

`ifdef DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (ovf_clr)                 r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_full = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator: averaging, gaps, saturation-free sums,
// FIFO full/drop/overflow, simultaneous push+pop at full, and mid-block reset.
module tb_fir_out_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        fifo_full;
  logic        overflow;
  logic        ovf_clr;
`ifdef DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  fir_out_decimator #(.DATA_W(16), .DECIM_LOG2(2), .DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
`ifdef DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 ns after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_block(input logic [15:0] d);
    for (int i = 0; i < 4; i++) send(d);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_full"},  32'(fifo_full), 32'd0);
    check({tag, "_ovf"},   32'(overflow),  32'd0);
  endtask

  // scoreboard of expected FIFO contents for the drain phases
  logic [15:0] exp_q[$];

  task automatic drain_and_check(input string tag);
    logic [15:0] e;
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"},  32'(out_data),  32'(e));
      tick();
    end
    check({tag, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    tick();
    tick();
    check_idle("reset");
`ifdef DROP_CNT_EN
    check("reset_dcnt", 32'(drop_cnt), 32'd0);
`endif
    rst = 1'b1;
    tick();

    // 1: (10+20+30+40)>>2 = 25, popped on the following edge
    send(16'd10);
    send(16'd20);
    send(16'd30);
    check("t1_no_early", 32'(out_valid), 32'd0);
    send(16'd40);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data",  32'(out_data),  32'd25);
    tick();
    check("t1_pop_valid", 32'(out_valid), 32'd0);
    check("t1_pop_data",  32'(out_data),  32'd0);

    // 2: gapped samples, 403>>2 = 100
    send(16'd100); tick();
    check("t2_gap1", 32'(out_valid), 32'd0);
    send(16'd100); tick();
    check("t2_gap2", 32'(out_valid), 32'd0);
    send(16'd100); tick();
    check("t2_gap3", 32'(out_valid), 32'd0);
    send(16'd103);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_data",  32'(out_data),  32'd100);
    tick();
    check("t2_pop", 32'(out_valid), 32'd0);

    // 3: 4*0xFFFF needs 18 bits; average must come back as 0xFFFF
    send_block(16'hFFFF);
    check("t3_data", 32'(out_data), 32'hFFFF);
    tick();

    // 4: fill, overflow on 5th block, drain in order, clear flag
    out_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      send_block(16'(b));
      if (b == 4) begin
        check("t4_full4", 32'(fifo_full), 32'd1);
        check("t4_ovf4",  32'(overflow),  32'd0);
        check("t4_head",  32'(out_data),  32'd1);
      end
    end
    check("t4_full5", 32'(fifo_full), 32'd1);
    check("t4_ovf5",  32'(overflow),  32'd1);
`ifdef DROP_CNT_EN
    check("t4_dcnt", 32'(drop_cnt), 32'd1);
`endif
    for (int b = 1; b <= 4; b++) exp_q.push_back(16'(b));
    drain_and_check("t4_drain");
    check("t4_notfull", 32'(fifo_full), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
`ifdef DROP_CNT_EN
    check("t4_dcnt_clr", 32'(drop_cnt), 32'd0);
`endif

    // 5: full FIFO, pop and push on the same edge
    out_ready = 1'b0;
    for (int b = 6; b <= 9; b++) send_block(16'(b));
    check("t5_full", 32'(fifo_full), 32'd1);
    send(16'd10);
    send(16'd10);
    send(16'd10);
    out_ready = 1'b1;
    send(16'd10);
    check("t5_full_kept", 32'(fifo_full), 32'd1);
    check("t5_no_ovf",    32'(overflow),  32'd0);
    for (int b = 7; b <= 10; b++) exp_q.push_back(16'(b));
    drain_and_check("t5_drain");

    // 6: reset mid-block discards the partial sum
    send(16'd50);
    send(16'd50);
    rst = 1'b0;
    tick();
    check_idle("t6_reset");
    rst = 1'b1;
    send_block(16'd8);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_data",  32'(out_data),  32'd8);
    tick();
    check("t6_pop", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
